// File: rtl/ex_stage.sv
// ex_stage: execute stage of a simple in-order pipeline.
// Computes ALU results, resolves branches and jumps, and buffers results in a
// 2-entry FIFO towards the memory stage. A taken branch/jump raises a
// one-cycle redirect pulse to fetch.
// Optional feature: define EX_PERF_EN to add flush_count_o, a saturating
// count of redirect pulses.
//
// Handshakes (valid/ready):
//   decode -> ex : an instruction transfers on a rising edge where
//                  in_valid_i && FD_pipeready && !branchtaken. An instruction
//                  offered while branchtaken is high is wrong-path and is
//                  consumed without effect.
//   ex -> memory : the head entry transfers on a rising edge where
//                  out_valid_o && mem_ready_i. While out_valid_o is high and
//                  mem_ready_i low, the head payload holds steady.
module ex_stage (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        in_valid_i,
    input  logic [63:0] pc_i,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        ALUSrc,
    input  logic        MemToReg,
    input  logic [2:0]  ALUOp,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [2:0]  I_Type,
    input  logic [63:0] immediate64bit,
    input  logic [31:0] rs1Out,
    input  logic [31:0] rs2Out,
    output logic        FD_pipeready,
    output logic        branchtaken,
    output logic [63:0] BranchALUXpipe_out,
    output logic        out_valid_o,
    input  logic        mem_ready_i,
    output logic [63:0] ALUResultX,
    output logic [63:0] StoreDataX,
    output logic [4:0]  rdX,
    output logic [2:0]  funct3X,
    output logic        RegWriteX,
    output logic        MemReadX,
    output logic        MemWriteX,
    output logic        MemToRegX
`ifdef EX_PERF_EN
    ,
    output logic [31:0] flush_count_o
`endif
);

    localparam logic [2:0] ITYPE_BRANCH = 3'd3;
    localparam logic [2:0] ITYPE_JUMP   = 3'd5;

    typedef struct packed {
        logic [63:0] alu;
        logic [63:0] store;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
    } entry_t;

    // Operands
    logic [63:0] op_a;
    logic [63:0] rs2_sext;
    logic [63:0] op_b;
    logic [5:0]  shamt;

    // ALU and branch resolution
    logic [63:0] alu_res;
    logic        signed_lt_ab;
    logic        signed_lt_br;
    logic        unsigned_lt_br;
    logic        br_eq;
    logic        br_cond;
    logic        is_branch;
    logic        is_jump;
    logic        taken;
    logic [63:0] target;
    entry_t      new_entry;

    // FIFO and control state
    entry_t      fifo_q [0:1];
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        branchtaken_q, branchtaken_d;
    logic [63:0] target_q, target_d;
    logic        accept;
    logic        deq;
    entry_t      head;

    assign op_a     = {{32{rs1Out[31]}}, rs1Out};
    assign rs2_sext = {{32{rs2Out[31]}}, rs2Out};
    assign op_b     = ALUSrc ? immediate64bit : rs2_sext;
    assign shamt    = op_b[5:0];

    assign signed_lt_ab   = $signed(op_a) < $signed(op_b);
    // Branch comparisons always use rs2, regardless of ALUSrc.
    assign signed_lt_br   = $signed(op_a) < $signed(rs2_sext);
    assign unsigned_lt_br = op_a < rs2_sext;
    assign br_eq          = op_a == rs2_sext;

    // ALU operation select
    always_comb begin
        alu_res = '0;
        case (ALUOp)
            3'd0:    alu_res = op_a + op_b;
            3'd1:    alu_res = op_a - op_b;
            3'd2:    alu_res = op_a & op_b;
            3'd3:    alu_res = op_a | op_b;
            3'd4:    alu_res = op_a ^ op_b;
            3'd5:    alu_res = {63'd0, signed_lt_ab};
            3'd6:    alu_res = op_a << shamt;
            3'd7:    alu_res = op_a >> shamt;
            default: alu_res = '0;
        endcase
    end

    // Branch condition by funct3; codes 2 and 3 never take
    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'd0:    br_cond = br_eq;
            3'd1:    br_cond = !br_eq;
            3'd4:    br_cond = signed_lt_br;
            3'd5:    br_cond = !signed_lt_br;
            3'd6:    br_cond = unsigned_lt_br;
            3'd7:    br_cond = !unsigned_lt_br;
            default: br_cond = 1'b0;
        endcase
    end

    assign is_branch = (I_Type == ITYPE_BRANCH);
    assign is_jump   = (I_Type == ITYPE_JUMP);
    assign taken     = is_jump || (is_branch && br_cond);
    assign target    = pc_i + immediate64bit;

    // Branch/jump control bits pass through untouched; jumps retire the link address.
    always_comb begin
        new_entry          = '0;
        new_entry.alu      = is_jump ? (pc_i + 64'd4) : alu_res;
        new_entry.store    = rs2_sext;
        new_entry.rd       = rd;
        new_entry.funct3   = funct3;
        new_entry.regwrite = RegWrite;
        new_entry.memread  = MemRead;
        new_entry.memwrite = MemWrite;
        new_entry.memtoreg = MemToReg;
    end

    assign FD_pipeready = (count_q < 2'd2) && !reset_i;
    assign accept       = in_valid_i && FD_pipeready && !branchtaken_q;
    assign out_valid_o  = (count_q != 2'd0);
    assign deq          = out_valid_o && mem_ready_i;

    // FIFO occupancy, pointers and redirect next state
    always_comb begin
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        branchtaken_d = accept && taken;
        target_d      = target_q;
        if (accept) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (deq) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({accept, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (accept && taken) begin
            target_d = target;
        end
    end

    // State registers; reset clears queue contents and any pending redirect
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q       <= '0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            branchtaken_q <= 1'b0;
            target_q      <= '0;
            fifo_q[0]     <= '0;
            fifo_q[1]     <= '0;
        end else begin
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            branchtaken_q <= branchtaken_d;
            target_q      <= target_d;
            if (accept) begin
                fifo_q[wr_ptr_q] <= new_entry;
            end
        end
    end

    assign head               = fifo_q[rd_ptr_q];
    assign ALUResultX         = head.alu;
    assign StoreDataX         = head.store;
    assign rdX                = head.rd;
    assign funct3X            = head.funct3;
    assign RegWriteX          = head.regwrite;
    assign MemReadX           = head.memread;
    assign MemWriteX          = head.memwrite;
    assign MemToRegX          = head.memtoreg;
    assign branchtaken        = branchtaken_q;
    assign BranchALUXpipe_out = target_q;

`ifdef EX_PERF_EN
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating count of redirect pulses
    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (branchtaken_q && (flush_cnt_q != 32'hFFFFFFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            flush_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign flush_count_o = flush_cnt_q;
`endif

endmodule
